axi_lite_user_bridge: RTL

AXI_LITE_USER_BRIDGE -- requirements
Module: axi_lite_user_bridge

---
 rtl/axi_lite_user_pkg.sv | 25 ++
 rtl/sat_counter.sv | 22 ++
 rtl/axi_lite_user_bridge.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_user_pkg.sv
// Shared types and constants for the AXI-Lite to user-bus bridge:
// FSM state encodings, AXI response codes and parameter helpers.
package axi_lite_user_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t WR_REQ  = 3'd1;
  localparam state_t RD_REQ  = 3'd2;
  localparam state_t WR_RESP = 3'd3;
  localparam state_t RD_RESP = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic bit data_w_legal(input int w);
    return (w == 32) || (w == 64);
  endfunction

  // Number of byte-offset bits dropped to word-align a user address.
  function automatic int addr_lsb(input int w);
    return (w == 64) ? 3 : 2;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc and holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count events, sticking at the maximum value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/axi_lite_user_bridge.sv
// AXI4-Lite slave that turns each transaction into one level-style request
// on a simple user bus, with alternating write/read arbitration and timeout.
module axi_lite_user_bridge
  import axi_lite_user_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
  input  logic                S_AXI_AWVALID,
  output logic                S_AXI_AWREADY,
  input  logic [DATA_W-1:0]   S_AXI_WDATA,
  input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
  input  logic                S_AXI_WVALID,
  output logic                S_AXI_WREADY,
  output logic [1:0]          S_AXI_BRESP,
  output logic                S_AXI_BVALID,
  input  logic                S_AXI_BREADY,
  input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
  input  logic                S_AXI_ARVALID,
  output logic                S_AXI_ARREADY,
  output logic [DATA_W-1:0]   S_AXI_RDATA,
  output logic [1:0]          S_AXI_RRESP,
  output logic                S_AXI_RVALID,
  input  logic                S_AXI_RREADY,
  output logic                usr_req,
  output logic                usr_we,
  output logic [ADDR_W-1:0]   usr_addr,
  output logic [DATA_W-1:0]   usr_wdata,
  output logic [DATA_W/8-1:0] usr_be,
  input  logic                usr_ack,
  input  logic                usr_err,
  input  logic [DATA_W-1:0]   usr_rdata,
  output logic [15:0]         err_cnt
);

  localparam int STRB_W = DATA_W / 8;
  localparam int TW     = $clog2(TIMEOUT);
  localparam logic [TW-1:0]     T_LAST     = TW'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << addr_lsb(DATA_W);

  if (!data_w_legal(DATA_W) || (TIMEOUT < 2)) begin : g_param_check
    $error("axi_lite_user_bridge: DATA_W must be 32 or 64 and TIMEOUT at least 2");
  end

  state_t              state;
  state_t              state_nx;
  logic                aw_held, w_held, ar_held;
  logic                aw_held_nx, w_held_nx, ar_held_nx;
  logic [ADDR_W-1:0]   aw_addr, ar_addr;
  logic [DATA_W-1:0]   w_data;
  logic [STRB_W-1:0]   w_strb;
  logic                last_wr;
  logic [TW-1:0]       tcount;

  logic                aw_hs, w_hs, ar_hs;
  logic                aw_have, w_have, ar_have;
  logic [ADDR_W-1:0]   cur_aw_addr, cur_ar_addr;
  logic [DATA_W-1:0]   cur_w_data;
  logic [STRB_W-1:0]   cur_w_strb;
  logic                grant_wr, grant_rd, collide;
  logic                ack, tmo, req_done, resp_err;

  // Beat capture and write/read arbitration; only meaningful in IDLE.
  always_comb begin
    aw_hs       = S_AXI_AWVALID && S_AXI_AWREADY;
    w_hs        = S_AXI_WVALID && S_AXI_WREADY;
    ar_hs       = S_AXI_ARVALID && S_AXI_ARREADY;
    aw_have     = aw_held || aw_hs;
    w_have      = w_held || w_hs;
    ar_have     = ar_held || ar_hs;
    cur_aw_addr = aw_held ? aw_addr : S_AXI_AWADDR;
    cur_ar_addr = ar_held ? ar_addr : S_AXI_ARADDR;
    cur_w_data  = w_held ? w_data : S_AXI_WDATA;
    cur_w_strb  = w_held ? w_strb : S_AXI_WSTRB;
    grant_wr    = 1'b0;
    grant_rd    = 1'b0;
    collide     = 1'b0;
    if (state == IDLE) begin
      collide  = aw_have && w_have && ar_have;
      grant_wr = aw_have && w_have && (!ar_have || !last_wr);
      grant_rd = ar_have && !grant_wr;
    end else begin
      collide  = 1'b0;
    end
  end

  // User-side completion: ack only counts while a request is outstanding.
  always_comb begin
    ack      = usr_req && usr_ack;
    tmo      = usr_req && !usr_ack && (tcount == T_LAST);
    req_done = ack || tmo;
    resp_err = tmo || usr_err;
  end

  // Next-state and next held-beat flags.
  always_comb begin
    state_nx   = state;
    aw_held_nx = aw_held;
    w_held_nx  = w_held;
    ar_held_nx = ar_held;
    if (state == IDLE) begin
      aw_held_nx = aw_have && !grant_wr;
      w_held_nx  = w_have && !grant_wr;
      ar_held_nx = ar_have && !grant_rd;
    end else begin
      aw_held_nx = aw_held;
    end
    case (state)
      IDLE: begin
        if (grant_wr) begin
          state_nx = (cur_w_strb == '0) ? WR_RESP : WR_REQ;
        end else if (grant_rd) begin
          state_nx = RD_REQ;
        end else begin
          state_nx = IDLE;
        end
      end
      WR_REQ:  state_nx = req_done ? WR_RESP : WR_REQ;
      RD_REQ:  state_nx = req_done ? RD_RESP : RD_REQ;
      WR_RESP: state_nx = (S_AXI_BVALID && S_AXI_BREADY) ? IDLE : WR_RESP;
      RD_RESP: state_nx = (S_AXI_RVALID && S_AXI_RREADY) ? IDLE : RD_RESP;
      default: state_nx = IDLE;
    endcase
  end

  // FSM, captured beats, arbitration history and registered READYs.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state         <= IDLE;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      ar_held       <= 1'b0;
      aw_addr       <= '0;
      ar_addr       <= '0;
      w_data        <= '0;
      w_strb        <= '0;
      last_wr       <= 1'b0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_ARREADY <= 1'b0;
    end else begin
      state   <= state_nx;
      aw_held <= aw_held_nx;
      w_held  <= w_held_nx;
      ar_held <= ar_held_nx;
      if (aw_hs) aw_addr <= S_AXI_AWADDR;
      if (w_hs) begin
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (ar_hs) ar_addr <= S_AXI_ARADDR;
      // Only true collisions move the fairness pointer.
      if (collide) last_wr <= grant_wr;
      S_AXI_AWREADY <= (state_nx == IDLE) && !aw_held_nx;
      S_AXI_WREADY  <= (state_nx == IDLE) && !w_held_nx;
      S_AXI_ARREADY <= (state_nx == IDLE) && !aw_held_nx && !w_held_nx && !ar_held_nx;
    end
  end

  // User request issue, timeout counting and AXI responses.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      usr_req      <= 1'b0;
      usr_we       <= 1'b0;
      usr_addr     <= '0;
      usr_wdata    <= '0;
      usr_be       <= '0;
      tcount       <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RRESP  <= RESP_OKAY;
      S_AXI_RDATA  <= '0;
    end else begin
      case (state)
        IDLE: begin
          tcount <= '0;
          if (grant_wr) begin
            if (cur_w_strb == '0) begin
              S_AXI_BVALID <= 1'b1;
              S_AXI_BRESP  <= RESP_OKAY;
            end else begin
              usr_req   <= 1'b1;
              usr_we    <= 1'b1;
              usr_addr  <= cur_aw_addr & ALIGN_MASK;
              usr_wdata <= cur_w_data;
              usr_be    <= cur_w_strb;
            end
          end else if (grant_rd) begin
            usr_req  <= 1'b1;
            usr_we   <= 1'b0;
            usr_addr <= cur_ar_addr & ALIGN_MASK;
          end else begin
            usr_req <= 1'b0;
          end
        end
        WR_REQ: begin
          if (req_done) begin
            usr_req      <= 1'b0;
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= resp_err ? RESP_SLVERR : RESP_OKAY;
          end else begin
            tcount <= tcount + TW'(1);
          end
        end
        RD_REQ: begin
          if (req_done) begin
            usr_req      <= 1'b0;
            S_AXI_RVALID <= 1'b1;
            S_AXI_RRESP  <= resp_err ? RESP_SLVERR : RESP_OKAY;
            S_AXI_RDATA  <= resp_err ? '0 : usr_rdata;
          end else begin
            tcount <= tcount + TW'(1);
          end
        end
        WR_RESP: begin
          if (S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
        end
        RD_RESP: begin
          if (S_AXI_RREADY) S_AXI_RVALID <= 1'b0;
        end
        default: begin
          usr_req      <= 1'b0;
          S_AXI_BVALID <= 1'b0;
          S_AXI_RVALID <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(16)) u_err_cnt (
    .clk   (ACLK),
    .rst   (ARESET),
    .inc   (req_done && resp_err),
    .count (err_cnt)
  );

endmodule
